pulse_period_meter: RTL

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

---
 rtl/pulse_period_meter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// Tick-to-tick period meter: counts clock cycles between tick strobes and hands
// each result over a valid/ready buffer. `PULSE_PERIOD_METER_MINMAX_EN adds min/max tracking.
module pulse_period_meter #(
  parameter int WIDTH = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun
`ifdef PULSE_PERIOD_METER_MINMAX_EN
  ,
  input  logic             clear_minmax,
  output logic [WIDTH-1:0] min_period,
  output logic [WIDTH-1:0] max_period
`endif
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, overrun_q;
  logic             res_fire, res_drop, cnt_full;

  assign cnt_full = (count_q == ALL_ONES);
  // A tick on the all-ones count still terminates a measurement, so it wins over timeout.
  assign res_fire = enable && (state_q == MEASURE) && tick;
  assign res_drop = res_fire && valid_q && !period_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        overrun_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (tick) begin
              count_q <= ONE;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (tick) begin
              count_q <= ONE;
            end else if (cnt_full) begin
              timeout_q <= 1'b1;
              state_q   <= ARM;
            end else begin
              count_q <= count_q + ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
        if (res_drop) overrun_q <= 1'b1;
      end
    end
  end

  // Output buffer runs regardless of enable so a pending result can drain.
  always_comb begin
    period_d = period_q;
    valid_d  = valid_q;
    if (res_fire && (!valid_q || period_ready)) begin
      period_d = count_q;
      valid_d  = 1'b1;
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      valid_q  <= valid_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

`ifdef PULSE_PERIOD_METER_MINMAX_EN
  logic [WIDTH-1:0] min_q, max_q;

  // Tracks every produced result, including ones the buffer had to drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= ALL_ONES;
      max_q <= '0;
    end else if (clear_minmax) begin
      min_q <= ALL_ONES;
      max_q <= '0;
    end else if (res_fire) begin
      if (count_q < min_q) min_q <= count_q;
      if (count_q > max_q) max_q <= count_q;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

endmodule
